// File: rtl/f_pc_npc.sv
// F-stage program counter and next-PC selector for the 5-stage MIPS pipeline.
// Resolves exception entry, stall, eret and D-stage branch/jump redirection into the fetch PC.
module f_pc_npc #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [31:0] IM_LO     = 32'h0000_3000,
   parameter logic [31:0] IM_HI     = 32'h0000_6ffc
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        stall_i,
   input  logic        req_i,
   input  logic        eret_i,
   input  logic [31:0] epc_i,
   input  logic [2:0]  npc_op_i,
   input  logic        b_jump_i,
   input  logic [31:0] d_pc_i,
   input  logic [15:0] d_imm16_i,
   input  logic [25:0] d_imm26_i,
   input  logic [31:0] d_rs_i,
   output logic [31:0] f_pc_o,
   output logic        f_bd_o,
   output logic        f_exc_adel_o,
   output logic        f_squash_o
);

   localparam logic [2:0] NpcSeq    = 3'd0;
   localparam logic [2:0] NpcBranch = 3'd1;
   localparam logic [2:0] NpcJump   = 3'd2;
   localparam logic [2:0] NpcJr     = 3'd3;

   logic [31:0] f_pc_q, f_pc_d;
   logic [31:0] seq_pc;
   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] br_offset;
   logic        is_branch, is_jump, is_jr;

   // Targets are computed unconditionally; selection below applies the priority.
   assign br_offset = {{14{d_imm16_i[15]}}, d_imm16_i, 2'b00};
   assign br_target = d_pc_i + 32'd4 + br_offset;
   assign j_target  = {d_pc_i[31:28], d_imm26_i, 2'b00};
   assign seq_pc    = f_pc_q + 32'd4;

   assign is_branch = (npc_op_i == NpcBranch);
   assign is_jump   = (npc_op_i == NpcJump);
   assign is_jr     = (npc_op_i == NpcJr);

   always_comb begin
      f_pc_d = seq_pc;
      if (req_i) begin
         f_pc_d = EXC_ENTRY;
      end else if (stall_i) begin
         f_pc_d = f_pc_q;
      end else if (eret_i) begin
         f_pc_d = epc_i;
      end else if (is_branch && b_jump_i) begin
         f_pc_d = br_target;
      end else if (is_jump) begin
         f_pc_d = j_target;
      end else if (is_jr) begin
         f_pc_d = d_rs_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         f_pc_q <= RESET_PC;
      end else begin
         f_pc_q <= f_pc_d;
      end
   end

   assign f_pc_o = f_pc_q;

   // Any control transfer in D marks the next fetch as a delay slot, taken or not.
   assign f_bd_o       = is_branch || is_jump || is_jr;
   assign f_exc_adel_o = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_LO) || (f_pc_q > IM_HI);
   assign f_squash_o   = eret_i && !stall_i && !req_i;

endmodule
